// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - regfile write-port arbiter for ALU and load-unit writeback
//
// Purpose: two 1-entry holding buffers (req 0 = ALU, req 1 = LSU) behind
// valid/ready handshakes. The two buffers share one registered regfile write port.
// Arbitration is oldest-first, and equal ages fall back to a round-robin pointer.
// A saturating counter tracks cycles where both buffers hold an entry.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      clears both buffers, blocks accepts and grants
//   alu_valid/ready/waddr/wdata  ALU writeback request channel
//   lsu_valid/ready/waddr/wdata  load writeback request channel
//   wen, waddr, wdata          registered regfile write port
//   idle                       no buffered entry and no write in flight
//   conflict_cnt               saturating count of contended cycles
//
// Optional feature (macro WB_BYPASS_EN): adds rs1_addr/rs2_addr inputs and
// byp_rs1/2_hit, byp_rs1/2_data outputs that forward the registered write
// to a regfile read in the same cycle.

module wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_waddr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              idle,
  output logic [CNT_W-1:0]  conflict_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              byp_rs1_hit,
  output logic              byp_rs2_hit,
  output logic [DATA_W-1:0] byp_rs1_data,
  output logic [DATA_W-1:0] byp_rs2_data
`endif
);

  logic [1:0]        buf_valid;
  logic [1:0]        age;
  logic [ADDR_W-1:0] buf_addr [2];
  logic [DATA_W-1:0] buf_data [2];
  logic              rr;

  logic [1:0]        grant;
  logic              rr_toggle;
  logic [1:0]        in_valid;
  logic [1:0]        ready;
  logic [1:0]        load;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];

  assign in_valid   = {lsu_valid, alu_valid};
  assign in_addr[0] = alu_waddr;
  assign in_addr[1] = lsu_waddr;
  assign in_data[0] = alu_wdata;
  assign in_data[1] = lsu_wdata;

  // Grant depends only on buffer state. With 1-entry buffers, at most one
  // entry can be age 1 at a time, so the age bit fully orders the entries.
  // Equal age happens only when both buffers loaded on the same edge.
  always_comb begin
    grant     = 2'b00;
    rr_toggle = 1'b0;
    if (!flush) begin
      if (buf_valid == 2'b11) begin
        if (age[0] != age[1]) begin
          grant = age[0] ? 2'b01 : 2'b10;
        end else begin
          grant     = rr ? 2'b10 : 2'b01;
          rr_toggle = 1'b1;
        end
      end else begin
        grant = buf_valid;
      end
    end
  end

  // A buffer being drained this cycle can take a new entry, so each
  // requester can sustain one write per cycle.
  assign ready     = {2{rst_n & ~flush}} & (~buf_valid | grant);
  assign alu_ready = ready[0];
  assign lsu_ready = ready[1];

  // Writes to x0 complete the handshake but are never buffered.
  assign load[0] = in_valid[0] & ready[0] & (in_addr[0] != '0);
  assign load[1] = in_valid[1] & ready[1] & (in_addr[1] != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid    <= 2'b00;
      age          <= 2'b00;
      rr           <= 1'b0;
      wen          <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush) begin
          buf_valid[i] <= 1'b0;
          age[i]       <= 1'b0;
        end else if (load[i]) begin
          buf_valid[i] <= 1'b1;
          age[i]       <= 1'b0;
          buf_addr[i]  <= in_addr[i];
          buf_data[i]  <= in_data[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
          age[i]       <= 1'b0;
        end else if (buf_valid[i]) begin
          age[i]       <= 1'b1;
        end
      end

      if (rr_toggle) begin
        rr <= ~rr;
      end

      wen <= |grant;
      if (grant[1]) begin
        waddr <= buf_addr[1];
        wdata <= buf_data[1];
      end else if (grant[0]) begin
        waddr <= buf_addr[0];
        wdata <= buf_data[0];
      end

      // A flush cycle issues no write, so it is not counted as contention.
      if ((buf_valid == 2'b11) && !flush && !(&conflict_cnt)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

  assign idle = ~buf_valid[0] & ~buf_valid[1] & ~wen;

`ifdef WB_BYPASS_EN
  assign byp_rs1_hit  = wen & (waddr == rs1_addr) & (rs1_addr != '0);
  assign byp_rs2_hit  = wen & (waddr == rs2_addr) & (rs2_addr != '0);
  assign byp_rs1_data = byp_rs1_hit ? wdata : '0;
  assign byp_rs2_data = byp_rs2_hit ? wdata : '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with a timestamp reference model

module tb_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_waddr = '0;
  logic [DW-1:0] alu_wdata = '0;
  logic          lsu_valid = 1'b0;
  logic          lsu_ready;
  logic [AW-1:0] lsu_waddr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          idle;
  logic [CW-1:0] conflict_cnt;
`ifdef WB_BYPASS_EN
  logic [AW-1:0] rs1_addr = '0;
  logic [AW-1:0] rs2_addr = '0;
  logic          byp_rs1_hit;
  logic          byp_rs2_hit;
  logic [DW-1:0] byp_rs1_data;
  logic [DW-1:0] byp_rs2_data;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .wen(wen), .waddr(waddr), .wdata(wdata), .idle(idle), .conflict_cnt(conflict_cnt)
`ifdef WB_BYPASS_EN
    ,
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .byp_rs1_hit(byp_rs1_hit), .byp_rs2_hit(byp_rs2_hit),
    .byp_rs1_data(byp_rs1_data), .byp_rs2_data(byp_rs2_data)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Reference model: each buffered entry carries the cycle it was loaded in.
  // The smallest stamp is written first, and equal stamps fall back to rr.
  bit            mv[2] = '{1'b0, 1'b0};
  int            ms[2] = '{0, 0};
  logic [AW-1:0] ma[2] = '{'0, '0};
  logic [DW-1:0] md[2] = '{'0, '0};
  bit            mrr = 1'b0;
  int            mcnt = 0;
  bit            mwen = 1'b0;
  logic [AW-1:0] mwaddr = '0;
  logic [DW-1:0] mwdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write cycle=%0d actual=addr %0d required=no write", cyc, waddr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(waddr), 64'(mon_e.a));
        chk("wr_data", 64'(wdata), 64'(mon_e.d));
        chk("wr_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  task automatic step(input bit r, input bit f,
                      input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    int            g;
    bit            tie;
    bit            rdy[2];
    bit            vin[2];
    logic [AW-1:0] ain[2];
    logic [DW-1:0] din[2];
    rst_n = r; flush = f;
    alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
    vin[0] = av; ain[0] = aa; din[0] = ad;
    vin[1] = lv; ain[1] = la; din[1] = ld;

    g = -1;
    tie = 1'b0;
    if (r && !f) begin
      if (mv[0] && mv[1]) begin
        if (ms[0] < ms[1]) g = 0;
        else if (ms[1] < ms[0]) g = 1;
        else begin g = int'(mrr); tie = 1'b1; end
      end else if (mv[0]) g = 0;
      else if (mv[1]) g = 1;
    end
    for (int i = 0; i < 2; i++) rdy[i] = r && !f && (!mv[i] || g == i);

    @(negedge clk);
    chk("alu_ready", 64'(alu_ready), 64'(rdy[0]));
    chk("lsu_ready", 64'(lsu_ready), 64'(rdy[1]));
    chk("wen", 64'(wen), 64'(mwen));
    chk("waddr", 64'(waddr), 64'(mwaddr));
    chk("wdata", 64'(wdata), 64'(mwdata));
    chk("idle", 64'(idle), 64'(!mv[0] && !mv[1] && !mwen));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(mcnt));
`ifdef WB_BYPASS_EN
    begin
      bit h1, h2;
      h1 = mwen && (mwaddr == rs1_addr) && (rs1_addr != 0);
      h2 = mwen && (mwaddr == rs2_addr) && (rs2_addr != 0);
      chk("byp_rs1_hit", 64'(byp_rs1_hit), 64'(h1));
      chk("byp_rs2_hit", 64'(byp_rs2_hit), 64'(h2));
      chk("byp_rs1_data", 64'(byp_rs1_data), h1 ? 64'(mwdata) : 64'd0);
      chk("byp_rs2_data", 64'(byp_rs2_data), h2 ? 64'(mwdata) : 64'd0);
    end
`endif

    if (!r) begin
      mv = '{1'b0, 1'b0};
      mrr = 1'b0; mcnt = 0; mwen = 1'b0; mwaddr = '0; mwdata = '0;
    end else begin
      if (mv[0] && mv[1] && !f && mcnt != (1 << CW) - 1) mcnt++;
      if (g >= 0) begin
        exp_q.push_back('{ma[g], md[g], cyc + 1});
        mwen = 1'b1; mwaddr = ma[g]; mwdata = md[g];
        if (tie) mrr = !mrr;
        mv[g] = 1'b0;
      end else begin
        mwen = 1'b0;
      end
      if (f) mv = '{1'b0, 1'b0};
      for (int i = 0; i < 2; i++) begin
        if (vin[i] && rdy[i] && ain[i] != 0) begin
          mv[i] = 1'b1; ms[i] = cyc; ma[i] = ain[i]; md[i] = din[i];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // reset held with a pending ALU request, then released
    for (int i = 0; i < 3; i++) step(0, 0, 1, 5'd9, 32'h1234, 0, '0, '0);
    step(1, 0, 0, '0, '0, 0, '0, '0);

    // single ALU write
    step(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    idle_steps(3);

    // same-edge tie on the same destination
    step(1, 0, 1, 5'd3, 32'd1, 1, 5'd3, 32'd2);
    idle_steps(3);

    // write to x0 is dropped
    step(1, 0, 0, '0, '0, 1, 5'd0, 32'hCAFE);
    idle_steps(2);

    // flush with both buffers full, then reset with both buffers full
    step(1, 0, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
    step(1, 1, 1, 5'd8, 32'h88, 1, 5'd9, 32'h99);
    idle_steps(2);
    step(1, 0, 1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
    step(0, 0, 0, '0, '0, 0, '0, '0);
    idle_steps(2);

    // back-to-back streams on both requesters
    for (int i = 1; i < 7; i++) step(1, 0, 1, AW'(i), DW'(i * 16), 1, AW'(i + 8), DW'(i * 256));
    idle_steps(3);

`ifdef WB_BYPASS_EN
    rs1_addr = 5'd7;
    rs2_addr = 5'd0;
    step(1, 0, 1, 5'd7, 32'h55, 0, '0, '0);
    idle_steps(3);
`endif

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
`ifdef WB_BYPASS_EN
      rs1_addr = AW'($urandom_range(0, 31));
      rs2_addr = AW'($urandom_range(0, 31));
`endif
      step($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0,
           1'($urandom), ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31)), $urandom,
           1'($urandom), ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31)), $urandom);
    end
    idle_steps(4);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
